// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and helpers for the ALU operand loader
// Purpose: loader state enum, ALU opcode type and the switch-to-operand fill rule.
// Ports: none (package).
package alu_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      ISSUE   = 1'b1
   } state_t;

   typedef logic [3:0] aluop_t;

   localparam int NUM_KEYS = 4;
   localparam int SW_W     = 18;
   localparam int DATA_W   = 32;

   // SW[15] replicates into the 17 upper bits, SW[14:0] is the value.
   function automatic logic [DATA_W-1:0] fill_value(input logic [15:0] sw);
      return {{17{sw[15]}}, sw[14:0]};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, debouncer and press-edge detector
// Purpose: cleans one raw active-low pushbutton and emits a one-cycle press pulse.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   key_raw_n - raw active-low button, asynchronous to clk
//   press     - one-cycle pulse on each debounced 1->0 transition
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_raw_n;
         sync2 <= sync1;
         press <= 1'b0;
         // Any cycle that agrees with the accepted level restarts the count,
         // so only an unbroken run of DEBOUNCE_CYCLES differing cycles flips it.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
            press <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - collects A/B/opcode from switches and issues them to an ALU
// Purpose: KEY0/1/2 load operand_a/operand_b/opcode, KEY3 issues the bundle
//          through a valid/ready handshake.
// Ports:
//   CLK        - rising-edge clock
//   RST        - synchronous active-high reset
//   KEY[3:0]   - raw active-low pushbuttons
//   SW[17:0]   - raw switches: [14:0] value, [15] upper fill, [3:0] opcode
//   req_ready  - ALU consumer ready
//   req_valid  - operand bundle valid
//   operand_a  - captured A
//   operand_b  - captured B
//   opcode     - captured ALU opcode
//   status     - {err, op_loaded, b_loaded, a_loaded}
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [3:0]        KEY,
   input  logic [SW_W-1:0]   SW,
   input  logic              req_ready,
   output logic              req_valid,
   output logic [DATA_W-1:0] operand_a,
   output logic [DATA_W-1:0] operand_b,
   output aluop_t            opcode,
   output logic [3:0]        status
);

   logic [SW_W-1:0]     sw_s1;
   logic [SW_W-1:0]     sw_s2;
   logic [NUM_KEYS-1:0] press;
   state_t              state;
   state_t              state_next;
   logic                a_loaded;
   logic                b_loaded;
   logic                op_loaded;
   logic                err;
   logic                all_loaded;
   logic                handshake;
   logic                issue_ok;
   logic                issue_bad;
   logic                unused_sw;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk      (CLK),
         .rst      (RST),
         .key_raw_n(KEY[i]),
         .press    (press[i])
      );
   end

   // Upper switches are synchronized with the rest but carry no function.
   assign unused_sw  = ^sw_s2[17:16];
   assign all_loaded = a_loaded & b_loaded & op_loaded;
   assign handshake  = req_valid & req_ready;
   assign status     = {err, op_loaded, b_loaded, a_loaded};

   always_comb begin
      state_next = state;
      issue_ok   = 1'b0;
      issue_bad  = 1'b0;
      case (state)
         COLLECT: begin
            // Flags here are the registered ones, so loads arriving in the
            // same cycle as the issue press do not count toward it.
            if (press[3]) begin
               if (all_loaded) begin
                  issue_ok   = 1'b1;
                  state_next = ISSUE;
               end else begin
                  issue_bad = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (handshake) state_next = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= COLLECT;
      else     state <= state_next;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sw_s1     <= '0;
         sw_s2     <= '0;
         req_valid <= 1'b0;
         operand_a <= '0;
         operand_b <= '0;
         opcode    <= '0;
         a_loaded  <= 1'b0;
         b_loaded  <= 1'b0;
         op_loaded <= 1'b0;
         err       <= 1'b0;
      end else begin
         sw_s1 <= SW;
         sw_s2 <= sw_s1;
         if (state == COLLECT) begin
            if (press[0]) begin
               operand_a <= fill_value(sw_s2[15:0]);
               a_loaded  <= 1'b1;
            end
            if (press[1]) begin
               operand_b <= fill_value(sw_s2[15:0]);
               b_loaded  <= 1'b1;
            end
            if (press[2]) begin
               opcode    <= sw_s2[3:0];
               op_loaded <= 1'b1;
            end
            // A failed issue in the same cycle as a load still reports err.
            if (|press[2:0]) err <= 1'b0;
            if (issue_bad)   err <= 1'b1;
            if (issue_ok)    req_valid <= 1'b1;
         end else if (handshake) begin
            req_valid <= 1'b0;
            a_loaded  <= 1'b0;
            b_loaded  <= 1'b0;
            op_loaded <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - self-checking bench for alu_operand_loader
module tb_alu_operand_loader;
   import alu_pkg::*;

   localparam int DC   = 16;
   localparam int HOLD = DC + 6;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  KEY;
   logic [17:0] SW;
   logic        req_ready;
   logic        req_valid;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   aluop_t      opcode;
   logic [3:0]  status;

   alu_operand_loader #(.DEBOUNCE_CYCLES(DC)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .KEY      (KEY),
      .SW       (SW),
      .req_ready(req_ready),
      .req_valid(req_valid),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .opcode   (opcode),
      .status   (status)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
   } bundle_t;

   int      checks = 0;
   int      errors = 0;
   int      press_cnt [4];
   int      hs_cnt = 0;
   bundle_t exp_q [$];
   bundle_t mon_e;

   // Reference model: architectural view of the loader, one step per press.
   logic [31:0] m_a, m_b;
   logic [3:0]  m_op;
   bit          m_fa, m_fb, m_fo, m_err, m_issue;

   function automatic logic [31:0] ext(input logic [17:0] s);
      logic signed [15:0] v;
      v = s[15:0];
      return 32'(int'(v));
   endfunction

   function automatic logic [3:0] m_status();
      return {m_err, m_fo, m_fb, m_fa};
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_op = 0;
      m_fa = 0; m_fb = 0; m_fo = 0; m_err = 0; m_issue = 0;
      exp_q.delete();
   endtask

   task automatic model_press(input int k, input logic [17:0] s);
      if (m_issue) return;
      case (k)
         0: begin m_a = ext(s); m_fa = 1; m_err = 0; end
         1: begin m_b = ext(s); m_fb = 1; m_err = 0; end
         2: begin m_op = s[3:0]; m_fo = 1; m_err = 0; end
         default: begin
            if (m_fa && m_fb && m_fo) begin
               if (req_ready) begin
                  exp_q.push_back('{a: m_a, b: m_b, op: m_op});
                  m_fa = 0; m_fb = 0; m_fo = 0;
               end else begin
                  m_issue = 1;
               end
            end else begin
               m_err = 1;
            end
         end
      endcase
   endtask

   always @(negedge CLK) begin
      for (int k = 0; k < 4; k++)
         if (dut.press[k] === 1'b1) press_cnt[k]++;
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
         hs_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL handshake_unexpected got a=%h b=%h op=%h required none", operand_a, operand_b, opcode);
         end else begin
            mon_e = exp_q.pop_front();
            if ({operand_a, operand_b, opcode} !== {mon_e.a, mon_e.b, mon_e.op}) begin
               errors++;
               $display("FAIL handshake_bundle got a=%h b=%h op=%h required a=%h b=%h op=%h",
                        operand_a, operand_b, opcode, mon_e.a, mon_e.b, mon_e.op);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #3;
   endtask

   task automatic press_key(input int k, input logic [17:0] s);
      SW = s;
      model_press(k, s);
      KEY[k] = 1'b0;
      repeat (HOLD) tick();
      KEY[k] = 1'b1;
      repeat (HOLD) tick();
   endtask

   task automatic test_reset();
      int base;
      checks++;
      if ({req_valid, operand_a, operand_b, opcode, status} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b a=%h b=%h op=%h st=%b required all 0",
                  req_valid, operand_a, operand_b, opcode, status);
      end
      base = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
      repeat (2 * DC) tick();
      checks++;
      if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] != base) begin
         errors++;
         $display("FAIL reset_no_press got %0d events required 0",
                  press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] - base);
      end
   endtask

   task automatic test_bounce();
      int base;
      logic [17:0] s;
      s = 18'($urandom);
      SW = s;
      base = press_cnt[0];
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) KEY[0] = ~KEY[0];
         tick();
      end
      KEY[0] = 1'b0;
      repeat (20) tick();
      model_press(0, s);
      checks++;
      if (press_cnt[0] - base != 1) begin
         errors++;
         $display("FAIL bounce_events got %0d required 1", press_cnt[0] - base);
      end
      checks++;
      if (operand_a !== m_a || status !== m_status()) begin
         errors++;
         $display("FAIL bounce_load got a=%h st=%b required a=%h st=%b", operand_a, status, m_a, m_status());
      end
      KEY[0] = 1'b1;
      repeat (HOLD) tick();
      checks++;
      if (press_cnt[0] - base != 1) begin
         errors++;
         $display("FAIL bounce_release got %0d events required 1", press_cnt[0] - base);
      end
   endtask

   task automatic test_transfer();
      bit seen;
      int hs0;
      req_ready = 1'b1;
      press_key(0, 18'h00005);
      press_key(1, 18'h00003);
      press_key(2, 18'h00002);
      checks++;
      if (status !== 4'b0111) begin
         errors++;
         $display("FAIL transfer_flags got %b required 0111", status);
      end
      hs0 = hs_cnt;
      model_press(3, SW);
      KEY[3] = 1'b0;
      seen = 0;
      for (int i = 0; i < HOLD + 4 && !seen; i++) begin
         tick();
         if (dut.press[3] === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL transfer_press_timeout got none required KEY3 press");
      end
      tick();
      checks++;
      if (req_valid !== 1'b1 || operand_a !== 32'h5 || operand_b !== 32'h3 || opcode !== 4'h2) begin
         errors++;
         $display("FAIL transfer_issue got v=%b a=%h b=%h op=%h required v=1 a=5 b=3 op=2",
                  req_valid, operand_a, operand_b, opcode);
      end
      tick();
      checks++;
      if (req_valid !== 1'b0 || status !== 4'b0000 || hs_cnt != hs0 + 1) begin
         errors++;
         $display("FAIL transfer_done got v=%b st=%b hs=%0d required v=0 st=0000 hs=%0d",
                  req_valid, status, hs_cnt - hs0, 1);
      end
      KEY[3] = 1'b1;
      repeat (HOLD) tick();
   endtask

   task automatic test_sign_fill();
      press_key(0, {2'b00, 1'b1, 15'h7FFF});
      checks++;
      if (operand_a !== 32'hFFFF_FFFF || operand_a !== m_a) begin
         errors++;
         $display("FAIL sign_fill got %h required ffffffff", operand_a);
      end
   endtask

   task automatic test_incomplete();
      int hs0;
      hs0 = hs_cnt;
      press_key(3, SW);
      checks++;
      if (status !== 4'b1001 || req_valid !== 1'b0 || hs_cnt != hs0) begin
         errors++;
         $display("FAIL incomplete_err got st=%b v=%b required st=1001 v=0", status, req_valid);
      end
      press_key(1, 18'($urandom));
      checks++;
      if (status !== 4'b0011 || operand_b !== m_b) begin
         errors++;
         $display("FAIL incomplete_clear got st=%b b=%h required st=0011 b=%h", status, operand_b, m_b);
      end
   endtask

   task automatic test_backpressure();
      bundle_t held;
      bit      seen;
      int      bad;
      int      hs0;
      press_key(2, 18'($urandom));
      req_ready = 1'b0;
      model_press(3, SW);
      held = '{a: m_a, b: m_b, op: m_op};
      KEY[3] = 1'b0;
      seen = 0;
      for (int i = 0; i < HOLD + 6 && !seen; i++) begin
         tick();
         if (req_valid === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL backpressure_valid_timeout got v=%b required 1", req_valid);
      end
      KEY[3] = 1'b1;
      model_press(0, 18'($urandom));
      SW = 18'($urandom);
      KEY[0] = 1'b0;
      bad = 0;
      for (int i = 0; i < 2 * HOLD; i++) begin
         if (i == HOLD) KEY[0] = 1'b1;
         tick();
         if (req_valid !== 1'b1 || {operand_a, operand_b, opcode} !== held) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold got %0d unstable cycles required 0", bad);
      end
      hs0 = hs_cnt;
      exp_q.push_back(held);
      req_ready = 1'b1;
      m_issue = 0; m_fa = 0; m_fb = 0; m_fo = 0;
      tick();
      checks++;
      if (req_valid !== 1'b0 || hs_cnt != hs0 + 1 || status !== 4'b0000 || operand_a !== held.a) begin
         errors++;
         $display("FAIL backpressure_release got v=%b hs=%0d st=%b a=%h required v=0 hs=1 st=0000 a=%h",
                  req_valid, hs_cnt - hs0, status, operand_a, held.a);
      end
   endtask

   task automatic test_reset_issue();
      bit seen;
      int base;
      int hs0;
      press_key(0, 18'($urandom));
      press_key(1, 18'($urandom));
      press_key(2, 18'($urandom));
      req_ready = 1'b0;
      model_press(3, SW);
      KEY[3] = 1'b0;
      seen = 0;
      for (int i = 0; i < HOLD + 6 && !seen; i++) begin
         tick();
         if (req_valid === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_issue_valid_timeout got v=%b required 1", req_valid);
      end
      KEY[3] = 1'b1;
      repeat (HOLD) tick();
      base = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
      hs0 = hs_cnt;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      model_reset();
      checks++;
      if ({req_valid, operand_a, operand_b, opcode, status} !== '0) begin
         errors++;
         $display("FAIL reset_issue_outputs got v=%b a=%h b=%h op=%h st=%b required all 0",
                  req_valid, operand_a, operand_b, opcode, status);
      end
      req_ready = 1'b1;
      repeat (2 * DC) tick();
      checks++;
      if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] != base || hs_cnt != hs0 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_issue_quiet got events=%0d hs=%0d v=%b required 0 0 0",
                  press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] - base, hs_cnt - hs0, req_valid);
      end
   endtask

   task automatic test_random();
      int k;
      req_ready = 1'b1;
      for (int n = 0; n < 14; n++) begin
         k = (n < 3) ? n : int'($urandom_range(3, 0));
         press_key(k, 18'($urandom));
         checks++;
         if ({operand_a, operand_b, opcode, status, req_valid} !== {m_a, m_b, m_op, m_status(), 1'b0}) begin
            errors++;
            $display("FAIL random_step%0d key%0d got a=%h b=%h op=%h st=%b v=%b required a=%h b=%h op=%h st=%b v=0",
                     n, k, operand_a, operand_b, opcode, status, req_valid, m_a, m_b, m_op, m_status());
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) press_cnt[k] = 0;
      RST = 1'b1;
      KEY = 4'hF;
      SW = '0;
      req_ready = 1'b0;
      model_reset();
      repeat (3) tick();
      RST = 1'b0;
      test_reset();
      test_bounce();
      test_transfer();
      test_sign_fill();
      test_incomplete();
      test_backpressure();
      test_reset_issue();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_handshakes got %0d outstanding required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
